// File: rtl/chip8_vram_scanout_pkg.sv
// Shared constants and types for the CHIP-8 VRAM scanout block.
`timescale 1ns/1ps
package chip8_vram_scanout_pkg;

   // CHIP-8 frame buffer geometry
   localparam int unsigned CHIP8_W = 64;
   localparam int unsigned CHIP8_H = 32;
   localparam int unsigned ROW_W   = 5;
   localparam int unsigned COL_W   = 6;

   // Counter and datapath widths
   localparam int unsigned CNT_W = 10;
   localparam int unsigned DIV_W = 4;
   localparam int unsigned SUB_W = 4;
   localparam int unsigned RGB_W = 12;

   // Default 640x480@60 timing
   localparam int unsigned PIX_DIV_DEF  = 2;
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam int unsigned SCALE_DEF    = 10;
   localparam int unsigned V_OFFSET_DEF = 80;

   localparam logic [RGB_W-1:0] FG_RGB = 12'hFFF;
   localparam logic [RGB_W-1:0] BG_RGB = 12'h000;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_ADDR,
      FETCH_WAIT,
      FETCH_LATCH
   } fetch_state_e;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } vga_sync_t;

endpackage

// File: rtl/chip8_vram_scanout_timing.sv
// Pixel-enable divider, h/v counters, registered sync/de and the frame tick.
`timescale 1ns/1ps
module chip8_vram_scanout_timing
   import chip8_vram_scanout_pkg::*;
#(
   parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF
) (
   input  logic             clk_i,
   input  logic             reset_i,
   output logic             pe_c,
   output logic [CNT_W-1:0] h_cnt_o,
   output logic [CNT_W-1:0] v_cnt_o,
   output vga_sync_t        sync_o,
   output logic             frame_tick_o
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_L  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_L  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_M1 = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   vga_sync_t        sync_q, sync_d;
   logic             tick_q, tick_d;

   assign pe_c = (div_q == DIV_LAST);

   // Next-state: divider, counter advance and one-pixel-late sync decode
   always_comb begin
      div_d  = pe_c ? '0 : div_q + DIV_W'(1);
      h_d    = h_q;
      v_d    = v_q;
      sync_d = sync_q;
      tick_d = 1'b0;
      if (pe_c) begin
         sync_d.hs = !((h_q >= HS_BEG) && (h_q <= HS_END));
         sync_d.vs = !((v_q >= VS_BEG) && (v_q <= VS_END));
         sync_d.de = (h_q < H_ACT_L) && (v_q < V_ACT_L);
         if (h_q == H_LAST) begin
            h_d    = '0;
            v_d    = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            tick_d = (v_q == V_ACT_M1);
         end else begin
            h_d = h_q + CNT_W'(1);
         end
      end
   end

   // Timing state registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_q  <= '0;
         h_q    <= '0;
         v_q    <= '0;
         sync_q <= '{hs: 1'b1, vs: 1'b1, de: 1'b0};
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         h_q    <= h_d;
         v_q    <= v_d;
         sync_q <= sync_d;
         tick_q <= tick_d;
      end
   end

   assign h_cnt_o      = h_q;
   assign v_cnt_o      = v_q;
   assign sync_o       = sync_q;
   assign frame_tick_o = tick_q;

endmodule

// File: rtl/chip8_vram_scanout.sv
// CHIP-8 VRAM port-B reader: per-line row fetch, pixel scaling and VGA colour output.
`timescale 1ns/1ps
module chip8_vram_scanout
   import chip8_vram_scanout_pkg::*;
#(
   parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter int unsigned SCALE    = SCALE_DEF,
   parameter int unsigned V_OFFSET = V_OFFSET_DEF
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   output logic [ROW_W-1:0]   vram_address_b,
   input  logic [CHIP8_W-1:0] vram_data_out_b,
   output logic [CHIP8_W-1:0] vram_data_in_b,
   output logic               vram_wren_b,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vga_de,
   output logic [RGB_W-1:0]   vga_rgb,
   output logic               frame_tick
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned WIN_W   = CHIP8_W * SCALE;
   localparam int unsigned WIN_H   = CHIP8_H * SCALE;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_L    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_L    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_WIN_L    = CNT_W'(WIN_W);
   localparam logic [CNT_W-1:0] V_OFF_L    = CNT_W'(V_OFFSET);
   localparam logic [CNT_W-1:0] V_PRE      = CNT_W'(V_OFFSET - 1);
   localparam logic [CNT_W-1:0] V_WIN_END  = CNT_W'(V_OFFSET + WIN_H);
   localparam logic [CNT_W-1:0] V_NEXT_END = CNT_W'(V_OFFSET + WIN_H - 1);
   localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SCALE - 1);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(CHIP8_W - 1);

   logic             pe;
   logic [CNT_W-1:0] h_cnt, v_cnt;
   vga_sync_t        sync;

   chip8_vram_scanout_timing #(
      .PIX_DIV (PIX_DIV),  .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk_i       (CLOCK_50),
      .reset_i     (reset),
      .pe_c        (pe),
      .h_cnt_o     (h_cnt),
      .v_cnt_o     (v_cnt),
      .sync_o      (sync),
      .frame_tick_o(frame_tick)
   );

   logic [SUB_W-1:0]   sub_x_q, sub_x_d, sub_y_q, sub_y_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   fetch_state_e       state_q, state_d;
   logic [ROW_W-1:0]   addr_q, addr_d;
   logic [CHIP8_W-1:0] line_buf_q, line_buf_d;
   logic [RGB_W-1:0]   rgb_q, rgb_d;

   logic               v_in_win, next_in_win, active, pix;
   logic [ROW_W-1:0]   next_row;

   assign v_in_win    = (v_cnt >= V_OFF_L) && (v_cnt < V_WIN_END);
   assign next_in_win = (v_cnt >= V_PRE) && (v_cnt < V_NEXT_END);
   assign next_row    = (v_cnt == V_PRE) ? '0 :
                        (sub_y_q == SUB_LAST) ? row_q + ROW_W'(1) : row_q;
   assign active      = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
   assign pix         = line_buf_q[COL_LAST - col_q];

   // Window sub-counters tracking the current h/v counter position
   always_comb begin
      sub_x_d = sub_x_q;
      col_d   = col_q;
      sub_y_d = sub_y_q;
      row_d   = row_q;
      if (pe) begin
         if (h_cnt == H_LAST) begin
            sub_x_d = '0;
            col_d   = '0;
            if (v_in_win) begin
               if (sub_y_q == SUB_LAST) begin
                  sub_y_d = '0;
                  row_d   = row_q + ROW_W'(1);
               end else begin
                  sub_y_d = sub_y_q + SUB_W'(1);
               end
            end else if (v_cnt == V_PRE) begin
               sub_y_d = '0;
               row_d   = '0;
            end
         end else if (sub_x_q == SUB_LAST) begin
            sub_x_d = '0;
            col_d   = col_q + COL_W'(1);
         end else begin
            sub_x_d = sub_x_q + SUB_W'(1);
         end
      end
   end

   // Row fetch FSM next-state plus registered colour mux
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      line_buf_d = line_buf_q;
      rgb_d      = rgb_q;
      case (state_q)
         FETCH_IDLE:  if (pe && (h_cnt == H_ACT_L) && next_in_win) state_d = FETCH_ADDR;
         FETCH_ADDR:  begin
            addr_d  = next_row;
            state_d = FETCH_WAIT;
         end
         FETCH_WAIT:  state_d = FETCH_LATCH;
         FETCH_LATCH: begin
            line_buf_d = vram_data_out_b;
            state_d    = FETCH_IDLE;
         end
         default:     state_d = FETCH_IDLE;
      endcase
      if (pe) begin
         if (!active)                                 rgb_d = '0;
         else if (v_in_win && (h_cnt < H_WIN_L) && pix) rgb_d = FG_RGB;
         else                                         rgb_d = BG_RGB;
      end
   end

   // Scanout state registers
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sub_x_q    <= '0;
         col_q      <= '0;
         sub_y_q    <= '0;
         row_q      <= '0;
         state_q    <= FETCH_IDLE;
         addr_q     <= '0;
         line_buf_q <= '0;
         rgb_q      <= '0;
      end else begin
         sub_x_q    <= sub_x_d;
         col_q      <= col_d;
         sub_y_q    <= sub_y_d;
         row_q      <= row_d;
         state_q    <= state_d;
         addr_q     <= addr_d;
         line_buf_q <= line_buf_d;
         rgb_q      <= rgb_d;
      end
   end

   assign vram_address_b = addr_q;
   assign vram_data_in_b = '0;
   assign vram_wren_b    = 1'b0;
   assign vga_hs         = sync.hs;
   assign vga_vs         = sync.vs;
   assign vga_de         = sync.de;
   assign vga_rgb        = rgb_q;

endmodule

// File: tb/tb_chip8_vram_scanout.sv
// Scoreboard bench: reduced-size raster, dual-port RAM model, random CPU writes.
`timescale 1ns/1ps
module tb_chip8_vram_scanout;

   // Reduced raster so several frames fit in a short run; SCALE=2 keeps sub-counters exercised
   localparam int PD = 2, SC = 2;
   localparam int HA = 128, HFP = 4, HSY = 8, HBP = 4, HT = HA + HFP + HSY + HBP;
   localparam int VA = 68,  VFP = 1, VSY = 2, VBP = 1, VT = VA + VFP + VSY + VBP;
   localparam int VO = 2, WH = 32 * SC;
   localparam int RUN_CYC = 44000;

   logic        clk = 1'b0, rst = 1'b1;
   logic [4:0]  addr_b;
   logic [63:0] dout_b, din_b;
   logic        wren_b, hs, vs, de, tick;
   logic [11:0] rgb;

   logic [63:0] mem [0:31];
   logic        we_a = 1'b0;
   logic [4:0]  addr_a = '0;
   logic [63:0] din_a = '0;

   int n = 0;
   logic rst_seen = 1'b0;
   logic done = 1'b0;
   int n_checks = 0, n_fails = 0;

   logic [14:0] exp_q [$];
   logic [63:0] line_data [0:VT-1];

   always #5 clk = ~clk;

   chip8_vram_scanout #(
      .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SCALE(SC), .V_OFFSET(VO)
   ) dut (
      .CLOCK_50(clk), .reset(rst), .vram_address_b(addr_b), .vram_data_out_b(dout_b),
      .vram_data_in_b(din_b), .vram_wren_b(wren_b), .vga_hs(hs), .vga_vs(vs),
      .vga_de(de), .vga_rgb(rgb), .frame_tick(tick)
   );

   // Dual-port RAM: port A written by the CPU side, port B registered read
   always @(posedge clk) begin
      if (we_a) mem[addr_a] <= din_a;
      dout_b <= mem[addr_b];
   end

   // Cycles since reset release
   always @(posedge clk) begin
      rst_seen <= rst;
      if (rst) n <= 0;
      else     n <= n + 1;
   end

   // Reference model: pixel k is live in the counters after edge PD*k+1
   always @(negedge clk) begin : model
      int k, h, v, vn;
      logic hs_e, vs_e, de_e;
      logic [11:0] rgb_e;
      if (rst_seen || n == 0) begin
         exp_q.delete();
      end else if (n % PD == 1) begin
         k  = (n - 1) / PD;
         h  = k % HT;
         v  = (k / HT) % VT;
         vn = (v + 1) % VT;
         de_e  = (h < HA) && (v < VA);
         hs_e  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
         vs_e  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
         rgb_e = 12'h000;
         if (de_e && v >= VO && v < VO + WH && h < 64 * SC && line_data[v][63 - h / SC])
            rgb_e = 12'hFFF;
         exp_q.push_back({hs_e, vs_e, de_e, rgb_e});
         if (h == HA && vn >= VO && vn < VO + WH) line_data[vn] = mem[(vn - VO) / SC];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
      end
   endtask

   // Monitor: reset values, per-pixel outputs, fetch address and frame tick
   always @(negedge clk) begin : monitor
      int k, h, v, vn, tick_count, last_tick_n;
      logic [14:0] e;
      logic exp_tick;
      if (rst_seen) begin
         chk("reset_outputs", {42'h0, hs, vs, de, rgb, tick, wren_b, addr_b},
             {42'h0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 5'h00});
         chk("reset_data_in_b", din_b, 64'h0);
         tick_count  = 0;
         last_tick_n = -1;
      end else if (n > 0) begin
         if (n % PD == 0) begin
            k  = n / PD - 1;
            h  = k % HT;
            v  = (k / HT) % VT;
            vn = (v + 1) % VT;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL scoreboard_empty at n=%0d: got no entry expected one", n);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("pixel h=%0d v=%0d", h, v), {49'h0, hs, vs, de, rgb}, {49'h0, e});
            end
            if (h == HA + 3 && vn >= VO && vn < VO + WH)
               chk("fetch_addr", {59'h0, addr_b}, 64'((vn - VO) / SC));
         end
         exp_tick = (n % PD == 0) && (((n / PD - 1) % (HT * VT)) == HT * VA - 1);
         chk("frame_tick", {63'h0, tick}, {63'h0, exp_tick});
         if (tick) begin
            tick_count++;
            if (last_tick_n >= 0) chk("tick_interval", 64'(n - last_tick_n), 64'(PD * HT * VT));
            last_tick_n = n;
         end
      end
      if (done) begin
         chk("tick_count", 64'(tick_count), 64'd2);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
         $finish;
      end
   end

   // Stimulus: preload, mid-line reset, then free-running frames with CPU writes
   initial begin : stim
      int p, h, v;
      logic row5_done;
      row5_done = 1'b0;
      repeat (3) @(posedge clk);
      for (int r = 0; r < 32; r++) begin
         @(negedge clk);
         we_a   = 1'b1;
         addr_a = 5'(r);
         din_a  = (r == 0) ? 64'h8000_0000_0000_0001 :
                  (r == 31) ? {64{1'b1}} : {$urandom, $urandom};
      end
      @(negedge clk);
      we_a = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (40 * HT * PD + 60) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < RUN_CYC; c++) begin
         @(negedge clk);
         we_a = 1'b0;
         p = n / PD;
         h = p % HT;
         v = (p / HT) % VT;
         if (!row5_done && c > 22000 && v == VO + 5 * SC && h == 10) begin
            we_a      = 1'b1;
            addr_a    = 5'd5;
            din_a     = {$urandom, $urandom};
            row5_done = 1'b1;
         end else if (h >= 2 && h <= HA - 20 && $urandom_range(0, 149) == 0) begin
            we_a   = 1'b1;
            addr_a = 5'($urandom_range(0, 31));
            din_a  = {$urandom, $urandom};
         end
      end
      @(negedge clk);
      we_a = 1'b0;
      done = 1'b1;
   end

endmodule
